// File: rtl/spi_frame_rx.sv
// -----------------------------------------------------------------------------
// spi_frame_rx
//   SPI slave front end that oversamples the PIC link in the clk domain. It
//   assembles FRAME_BITS-bit frames (MSB first), shifts a reply word out on
//   sdi, and publishes the newest complete frame on q at the start of vsync.
//   As a result, downstream game state only changes between video frames.
//
// Build option:
//   SPI_TIMEOUT_EN - when defined, the receiver drops a partial frame after
//                    TIMEOUT_CYC idle clk cycles in SHIFT, which realigns the
//                    framing. When undefined, only reset_b realigns it.
//
// Ports:
//   clk          system clock, at least 8x the sck frequency
//   reset_b      asynchronous reset, active low
//   sck, sdo     SPI clock (idle low) and data from the PIC, both asynchronous
//   vsync        active-low sync from the video controller, asynchronous
//   d            reply word, loaded into the reply shifter at frame completion
//   sdi          SPI data back to the PIC
//   q            last published frame
//   frame_valid  one-cycle pulse when q updates
//   busy         1 while a frame is being shifted
//   drop_cnt     frames overwritten before publication (saturates at 255)
// -----------------------------------------------------------------------------
module spi_frame_rx #(
   parameter int FRAME_BITS  = 32,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                  clk,
   input  logic                  reset_b,
   input  logic                  sck,
   input  logic                  sdo,
   input  logic                  vsync,
   input  logic [FRAME_BITS-1:0] d,
   output logic                  sdi,
   output logic [FRAME_BITS-1:0] q,
   output logic                  frame_valid,
   output logic                  busy,
   output logic [7:0]            drop_cnt
);

   localparam int CW = $clog2(FRAME_BITS);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   // Synchronisers. sdo goes through the same depth as sck, so sdo_s is the
   // data that was on the pin when the detected sck edge happened.
   logic [SYNC_STAGES-1:0] sck_sync, sdo_sync, vs_sync;
   logic                   sck_d, vs_d;
   logic                   sck_s, sdo_s, vs_s;
   logic                   sck_fall, vs_fall;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         sck_sync <= '0;
         sdo_sync <= '0;
         vs_sync  <= '0;
         sck_d    <= 1'b0;
         vs_d     <= 1'b0;
      end else begin
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
         sdo_sync <= {sdo_sync[SYNC_STAGES-2:0], sdo};
         vs_sync  <= {vs_sync[SYNC_STAGES-2:0], vsync};
         sck_d    <= sck_s;
         vs_d     <= vs_s;
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign sdo_s    = sdo_sync[SYNC_STAGES-1];
   assign vs_s     = vs_sync[SYNC_STAGES-1];
   assign sck_fall = sck_d & ~sck_s;
   assign vs_fall  = vs_d & ~vs_s;   // vsync is active low: a fall starts the pulse

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [FRAME_BITS-2:0] qsr;       // only the low bits ever reach a frame
   logic [FRAME_BITS-1:0] dsr;
   logic [FRAME_BITS-1:0] qbuf;
   logic                  pending;
   logic                  timeout;
   logic                  last_bit;
   logic                  frame_done;
   logic [FRAME_BITS-1:0] new_word;

   assign last_bit   = (cnt == CW'(FRAME_BITS-1));
   assign frame_done = sck_fall & last_bit;
   assign new_word   = {qsr, sdo_s};

`ifdef SPI_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC+1);
   logic [TW-1:0] idle_cnt;
   logic          sck_edge;

   assign sck_edge = sck_d ^ sck_s;
   assign timeout  = (state == SHIFT) && !sck_edge && (idle_cnt == TW'(TIMEOUT_CYC));

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b)
         idle_cnt <= '0;
      else if (state != SHIFT || sck_edge || timeout)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + TW'(1);
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state       <= IDLE;
         busy        <= 1'b0;
         cnt         <= '0;
         qsr         <= '0;
         dsr         <= '0;
         qbuf        <= '0;
         q           <= '0;
         pending     <= 1'b0;
         frame_valid <= 1'b0;
         drop_cnt    <= '0;
         sdi         <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         sdi         <= dsr[FRAME_BITS-1];

         // Shift path
         if (sck_fall) begin
            qsr <= new_word[FRAME_BITS-2:0];
            if (last_bit) begin
               cnt <= '0;
               dsr <= d;
            end else begin
               cnt <= cnt + CW'(1);
               dsr <= {dsr[FRAME_BITS-2:0], 1'b0};
            end
         end else if (timeout) begin
            // Drop the partial frame. qbuf, pending and drop_cnt are untouched.
            cnt <= '0;
            dsr <= d;
            qsr <= '0;
         end

         // FSM
         case (state)
            IDLE:
               if (sck_fall) begin
                  state <= SHIFT;
                  busy  <= 1'b1;
               end
            SHIFT:
               if (frame_done || timeout) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase

         // Publication. A frame that completes on the vsync edge goes straight
         // to q. Whatever was waiting in qbuf is superseded and is not counted
         // as a drop.
         if (frame_done && vs_fall) begin
            q           <= new_word;
            frame_valid <= 1'b1;
            pending     <= 1'b0;
         end else if (frame_done) begin
            qbuf    <= new_word;
            pending <= 1'b1;
            if (pending && drop_cnt != 8'hFF)
               drop_cnt <= drop_cnt + 8'd1;
         end else if (vs_fall && pending) begin
            q           <= qbuf;
            frame_valid <= 1'b1;
            pending     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_frame_rx.sv
module tb_spi_frame_rx;

   localparam int FB = 32;
`ifdef SPI_TIMEOUT_EN
   localparam int TO    = 64;
   localparam bit TO_EN = 1'b1;
`else
   localparam int TO    = 4096;
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_b = 1'b0;
   logic          sck = 1'b0;
   logic          sdo = 1'b0;
   logic          vsync = 1'b1;
   logic [FB-1:0] d = '0;
   logic          sdi;
   logic [FB-1:0] q;
   logic          frame_valid;
   logic          busy;
   logic [7:0]    drop_cnt;

   spi_frame_rx #(.FRAME_BITS(FB), .SYNC_STAGES(2), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset_b(reset_b), .sck(sck), .sdo(sdo), .vsync(vsync), .d(d),
      .sdi(sdi), .q(q), .frame_valid(frame_valid), .busy(busy), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: a stream of received bits cut into FB-bit frames.
   bit            m_bits[$];
   logic [FB-1:0] m_reply;   // word the PIC reads back during the next frame
   logic [FB-1:0] m_buf;
   bit            m_pend;
   int            m_drop;
   logic [FB-1:0] exp_q[$];  // scoreboard of expected publications

   task automatic chk(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic void m_reset();
      m_bits.delete();
      m_reply = '0;
      m_buf   = '0;
      m_pend  = 1'b0;
      m_drop  = 0;
   endfunction

   function automatic void m_vsync();
      if (m_pend) begin
         exp_q.push_back(m_buf);
         m_pend = 1'b0;
      end
   endfunction

   function automatic void m_bit(input bit b, input bit vs);
      logic [FB-1:0] w;
      m_bits.push_back(b);
      if (m_bits.size() == FB) begin
         w = '0;
         foreach (m_bits[i]) w = {w[FB-2:0], m_bits[i]};
         m_bits.delete();
         m_reply = d;
         if (vs) begin
            exp_q.push_back(w);
            m_pend = 1'b0;
         end else begin
            if (m_pend && m_drop < 255) m_drop++;
            m_buf  = w;
            m_pend = 1'b1;
         end
      end else if (vs) begin
         m_vsync();
      end
   endfunction

   // Monitor: every frame_valid pulse must match the next expected word.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (frame_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame_valid actual q=%h required no pulse", q);
            end else begin
               chk("q_publish", q, exp_q.pop_front());
            end
         end
      end
   end

   // One SPI bit, period 10 clk. sdo is set well before the rise and held past
   // the fall. sdi is read while sck is high, just before the fall.
   task automatic send_bit(input bit b, input bit vs_co, output bit s);
      sdo = b;
      repeat (2) @(negedge clk);
      sck = 1'b1;
      repeat (5) @(negedge clk);
      s   = sdi;
      sck = 1'b0;
      if (vs_co) vsync = 1'b0;
      m_bit(b, vs_co);
      repeat (3) @(negedge clk);
   endtask

   task automatic send_frame(input logic [FB-1:0] w, input bit vs_co);
      bit            aligned;
      bit            s;
      logic [FB-1:0] rep;
      logic [FB-1:0] exp_rep;
      aligned = (m_bits.size() == 0);
      exp_rep = m_reply;
      rep     = '0;
      for (int i = FB-1; i >= 0; i--) begin
         send_bit(w[i], vs_co && (i == 0), s);
         rep = {rep[FB-2:0], s};
         if (aligned && i == FB-1) chk("busy_mid_frame", {31'b0, busy}, 32'd1);
      end
      if (vs_co) begin
         repeat (3) @(negedge clk);
         vsync = 1'b1;
      end
      repeat (4) @(negedge clk);
      if (aligned) begin
         chk("sdi_reply", rep, exp_rep);
         chk("busy_idle", {31'b0, busy}, 32'd0);
      end
      chk("drop_cnt", {24'b0, drop_cnt}, m_drop);
   endtask

   task automatic vsync_pulse();
      vsync = 1'b0;
      m_vsync();
      repeat (5) @(negedge clk);
      vsync = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic stall(input int n);
      repeat (n) @(negedge clk);
      if (TO_EN && n > TO) begin
         m_bits.delete();
         m_reply = d;
      end
   endtask

   task automatic do_reset();
      chk("scoreboard_drained", exp_q.size(), 0);
      reset_b = 1'b0;
      sck     = 1'b0;
      sdo     = 1'b0;
      vsync   = 1'b1;
      repeat (3) @(negedge clk);
      reset_b = 1'b1;
      m_reset();
      repeat (4) @(negedge clk);
   endtask

   initial begin
      bit s;
      m_reset();

      // T1: reset held while the pins toggle
      reset_b = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         sck   = 1'($urandom_range(0, 1));
         sdo   = 1'($urandom_range(0, 1));
         vsync = 1'($urandom_range(0, 1));
      end
      chk("reset_q", q, '0);
      chk("reset_sdi", {31'b0, sdi}, 32'd0);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_drop", {24'b0, drop_cnt}, 32'd0);
      chk("reset_fv", {31'b0, frame_valid}, 32'd0);
      sck = 1'b0; sdo = 1'b0; vsync = 1'b1;
      repeat (3) @(negedge clk);
      reset_b = 1'b1;
      repeat (4) @(negedge clk);

      // T2: basic frame
      send_frame(32'hDEADBEEF, 1'b0);
      vsync_pulse();

      // T3: reply path; the first frame after reset replies zeros
      do_reset();
      d = 32'hA5A5_0F0F;
      send_frame($urandom, 1'b0);
      send_frame($urandom, 1'b0);
      vsync_pulse();

      // T4: overrun
      do_reset();
      send_frame(32'h1, 1'b0);
      send_frame(32'h2, 1'b0);
      send_frame(32'h3, 1'b0);
      vsync_pulse();
      chk("t4_drop", {24'b0, drop_cnt}, 32'd2);

      // T5: frame completion lands on the vsync edge
      send_frame($urandom, 1'b1);
      send_frame($urandom, 1'b0);
      send_frame($urandom, 1'b1);

      // Randomised traffic
      for (int n = 0; n < 24; n++) begin
         d = $urandom;
         send_frame($urandom, $urandom_range(0, 5) == 0);
         if ($urandom_range(0, 2) == 0) vsync_pulse();
      end
      vsync_pulse();

      // T6: partial frame, stall, full frame
      do_reset();
      d = $urandom;
      for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, s);
      stall(100);
      send_frame(32'h12345678, 1'b0);
      vsync_pulse();
      do_reset();

      repeat (10) @(negedge clk);
      chk("scoreboard_final", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
